sprite_layer: RTL and testbench

Parametrised sprite renderer for the chess display: draws one ROM-stored piece sprite at a runtime board position with integer scaling (1x–4x) and index-keyed transparency. It replaces full-screen per-pixel multiply/divide addressing with incremental counters and a fixed-latency pipeline. One instance is used per drawn layer (piece, cursor, captured piece), and the parent compositor takes the output when `pix_valid` is high.

---
 rtl/sprite_layer.sv | 170 +++++++++++++++++
 tb/tb_sprite_layer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer.sv
// Scaled ROM sprite renderer with index-keyed transparency; pixel for DrawX=x appears 3 cycles later.
// Optional feature macro: SPRITE_HIGHLIGHT_EN (adds latched `highlight`, transparent in-box texels show HL_RGB).
module sprite_layer #(
    parameter int unsigned SPR_W      = 55,
    parameter int unsigned SPR_H      = 55,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned TRANSP_IDX = 0,
    parameter logic [11:0] HL_RGB     = 12'h0F0
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        scale,
    input  logic              enable,
`ifdef SPRITE_HIGHLIGHT_EN
    input  logic              highlight,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              pix_valid
);

    localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

    logic              hl_in;
    logic [9:0]        sh_pos_x, sh_pos_y;
    logic [1:0]        sh_scale;
    logic              sh_en, sh_hl;
    logic              frame_start;
    logic [9:0]        px, py;
    logic [1:0]        sc;
    logic              en, hl;
    logic [10:0]       box_w, box_h;
    logic              x_in, y_in, in_box, line_start;

    logic [CW-1:0]     col, col_n;
    logic [1:0]        col_sub, col_sub_n, row_sub, row_sub_n;
    logic [ADDR_W-1:0] row_base, row_base_n;
    logic              active, active_n;

    logic [1:0]        box_d, blank_d, hl_d;
    logic              opaque, hl_pix;
    logic [11:0]       rgb_n;

`ifdef SPRITE_HIGHLIGHT_EN
    assign hl_in = highlight;
`else
    assign hl_in = 1'b0;
`endif

    // The latch cycle itself already sees the incoming values, so a sprite at (0,0) is not lost.
    always_comb begin
        frame_start = (DrawX == '0) && (DrawY == '0);
        px = frame_start ? pos_x  : sh_pos_x;
        py = frame_start ? pos_y  : sh_pos_y;
        sc = frame_start ? scale  : sh_scale;
        en = frame_start ? enable : sh_en;
        hl = frame_start ? hl_in  : sh_hl;
    end

    always_comb begin
        case (sc)
            2'd0:    begin box_w = 11'(SPR_W);     box_h = 11'(SPR_H);     end
            2'd1:    begin box_w = 11'(2 * SPR_W); box_h = 11'(2 * SPR_H); end
            2'd2:    begin box_w = 11'(3 * SPR_W); box_h = 11'(3 * SPR_H); end
            default: begin box_w = 11'(4 * SPR_W); box_h = 11'(4 * SPR_H); end
        endcase
        x_in       = ({1'b0, DrawX} >= {1'b0, px}) && ({1'b0, DrawX} < ({1'b0, px} + box_w));
        y_in       = ({1'b0, DrawY} >= {1'b0, py}) && ({1'b0, DrawY} < ({1'b0, py} + box_h));
        in_box     = en && x_in && y_in;
        line_start = (DrawX == px) && y_in;
    end

    always_comb begin
        col_n      = col;
        col_sub_n  = col_sub;
        row_sub_n  = row_sub;
        row_base_n = row_base;
        active_n   = active;
        if (line_start) begin
            if (DrawY == py) begin
                row_sub_n  = '0;
                row_base_n = '0;
            end else if (row_sub == sc) begin
                row_sub_n  = '0;
                row_base_n = row_base + ADDR_W'(SPR_W);
            end else begin
                row_sub_n  = row_sub + 2'd1;
            end
            col_n     = '0;
            col_sub_n = '0;
            active_n  = 1'b1;
        end else if (active) begin
            if (col_sub == sc) begin
                col_sub_n = '0;
                if (col == CW'(SPR_W - 1)) active_n = 1'b0;
                else                       col_n    = col + 1'b1;
            end else begin
                col_sub_n = col_sub + 2'd1;
            end
        end
    end

    assign pal_index = rom_q;

    always_comb begin
        opaque = box_d[1] && blank_d[1] && (rom_q != IDX_W'(TRANSP_IDX));
        hl_pix = box_d[1] && blank_d[1] && hl_d[1] && (rom_q == IDX_W'(TRANSP_IDX));
        rgb_n  = '0;
        if (opaque)      rgb_n = {pal_red, pal_green, pal_blue};
        else if (hl_pix) rgb_n = HL_RGB;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_pos_x  <= '0;
            sh_pos_y  <= '0;
            sh_scale  <= '0;
            sh_en     <= 1'b0;
            sh_hl     <= 1'b0;
            col       <= '0;
            col_sub   <= '0;
            row_sub   <= '0;
            row_base  <= '0;
            active    <= 1'b0;
            rom_addr  <= '0;
            box_d     <= '0;
            blank_d   <= '0;
            hl_d      <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            pix_valid <= 1'b0;
        end else begin
            if (frame_start) begin
                sh_pos_x <= pos_x;
                sh_pos_y <= pos_y;
                sh_scale <= scale;
                sh_en    <= enable;
                sh_hl    <= hl_in;
            end
            col       <= col_n;
            col_sub   <= col_sub_n;
            row_sub   <= row_sub_n;
            row_base  <= row_base_n;
            active    <= active_n;
            rom_addr  <= row_base_n + ADDR_W'(col_n);
            box_d     <= {box_d[0], in_box};
            blank_d   <= {blank_d[0], blank};
            hl_d      <= {hl_d[0], hl};
            red       <= rgb_n[11:8];
            green     <= rgb_n[7:4];
            blue      <= rgb_n[3:0];
            pix_valid <= opaque || hl_pix;
        end
    end

endmodule

// File: tb/tb_sprite_layer.sv
// Scoreboard bench for sprite_layer: a geometric reference model queues expected pixels, a monitor compares them.
module tb_sprite_layer;

    localparam int unsigned SPR_W  = 55;
    localparam int unsigned SPR_H  = 55;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned TRANSP = 0;

    logic              vga_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [9:0]        DrawX = '0, DrawY = '0;
    logic              blank = 1'b0;
    logic [9:0]        pos_x = '0, pos_y = '0;
    logic [1:0]        scale = '0;
    logic              enable = 1'b0;
`ifdef SPRITE_HIGHLIGHT_EN
    logic              highlight = 1'b0;
`endif
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q, pal_index;
    logic [3:0]        pal_red, pal_green, pal_blue, red, green, blue;
    logic              pix_valid;

    sprite_layer #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
        .TRANSP_IDX(TRANSP), .HL_RGB(12'h0F0)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .enable(enable),
`ifdef SPRITE_HIGHLIGHT_EN
        .highlight(highlight),
`endif
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue), .pix_valid(pix_valid)
    );

    always #5 vga_clk = ~vga_clk;

    logic [IDX_W-1:0] rom [0:(1<<ADDR_W)-1];
    always @(posedge vga_clk) rom_q <= rom[rom_addr];

    function automatic logic [11:0] pal(input logic [IDX_W-1:0] i);
        case (i)
            2'd0:    pal = 12'h123;
            2'd1:    pal = 12'hF00;
            2'd2:    pal = 12'h0AF;
            default: pal = 12'hFF5;
        endcase
    endfunction
    assign {pal_red, pal_green, pal_blue} = pal(pal_index);

    typedef struct {
        int          due;
        int          x;
        int          y;
        logic        pv;
        logic [11:0] rgb;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    // reference model state: values captured at the (0,0) frame-latch pixel
    int mpx = 0, mpy = 0, msc = 0;
    bit men = 0, mhl = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge vga_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL stale(%0d,%0d): got no output slot expected pv=%0d rgb=%h", e.x, e.y, e.pv, e.rgb);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n_checks++;
            if ({pix_valid, red, green, blue} !== {e.pv, e.rgb}) begin
                n_fail++;
                $display("FAIL pix(%0d,%0d): got pv=%0d rgb=%h expected pv=%0d rgb=%h",
                         e.x, e.y, pix_valid, {red, green, blue}, e.pv, e.rgb);
            end
        end
    end

    task automatic push_expect(input int x, input int y, input bit b);
        exp_t e;
        int s, w, h, idx;
        if (x == 0 && y == 0) begin
            mpx = int'(pos_x);
            mpy = int'(pos_y);
            msc = int'(scale);
            men = enable;
`ifdef SPRITE_HIGHLIGHT_EN
            mhl = highlight;
`else
            mhl = 1'b0;
`endif
        end
        s = msc + 1;
        w = SPR_W * s;
        h = SPR_H * s;
        e.due = cyc + 3;
        e.x   = x;
        e.y   = y;
        e.pv  = 1'b0;
        e.rgb = '0;
        if (men && b && x >= mpx && x < mpx + w && y >= mpy && y < mpy + h) begin
            idx = int'(rom[((y - mpy) / s) * SPR_W + (x - mpx) / s]);
            if (idx != TRANSP) begin
                e.pv  = 1'b1;
                e.rgb = pal(IDX_W'(idx));
            end else if (mhl) begin
                e.pv  = 1'b1;
                e.rgb = 12'h0F0;
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive(input int x, input int y);
        @(posedge vga_clk);
        #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = (x < 640) && (y < 480);
        push_expect(x, y, blank);
    endtask

    task automatic scan(input int y0, input int y1, input int xs, input int xe);
        int lo, hi;
        lo = (xs < 0) ? 0 : xs;
        hi = (xe > 799) ? 799 : xe;
        for (int y = y0; y <= y1; y++)
            for (int x = lo; x <= hi; x++) drive(x, y);
    endtask

    task automatic start_frame();
        scan(0, 0, 0, 3);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_pix_valid"}, int'(pix_valid), 0);
        chk({tag, "_rgb"}, int'({red, green, blue}), 0);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = IDX_W'($urandom_range(0, 3));
        rom[0] = 2'd1;
        rom[1] = 2'd0;
        rom[2] = 2'd2;

        repeat (3) @(posedge vga_clk);
        #1;
        check_zero_outputs("reset");
        reset_n = 1'b1;

        // basic placement, 1x (also transparent texel 1 next to opaque texels 0 and 2)
        pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0; enable = 1'b1;
        start_frame();
        scan(49, 105, 95, 160);

        // 2x scaling
        scale = 2'd1;
        start_frame();
        scan(49, 161, 95, 215);

        // disabled layer draws nothing
        enable = 1'b0;
        start_frame();
        scan(49, 55, 95, 160);
        enable = 1'b1;

        // right/bottom clipping at 4x
        pos_x = 10'd600; pos_y = 10'd450; scale = 2'd3;
        start_frame();
        scan(449, 485, 590, 799);

        // mid-frame position change waits for the next frame
        pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0;
        start_frame();
        scan(49, 59, 90, 270);
        pos_x = 10'd200;
        scan(60, 70, 90, 270);
        start_frame();
        scan(49, 70, 90, 270);

`ifdef SPRITE_HIGHLIGHT_EN
        highlight = 1'b1;
        pos_x = 10'd100;
        start_frame();
        scan(50, 56, 95, 160);
        highlight = 1'b0;
`endif

        // reset in the middle of a sprite line
        pos_x = 10'd300; pos_y = 10'd200; scale = 2'd0;
        start_frame();
        scan(200, 209, 290, 360);
        scan(210, 210, 290, 320);
        @(posedge vga_clk);
        #2 reset_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        sb.delete();
        mpx = 0; mpy = 0; msc = 0; men = 1'b0; mhl = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1 reset_n = 1'b1;
        scan(211, 230, 290, 360);
        start_frame();
        scan(200, 206, 290, 360);

        // randomized placement, scale and enable
        for (int f = 0; f < 3; f++) begin
            int w;
            pos_x  = 10'($urandom_range(5, 700));
            pos_y  = 10'($urandom_range(3, 470));
            scale  = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 3) != 0);
            w = SPR_W * (int'(scale) + 1);
            start_frame();
            scan(int'(pos_y) - 1, int'(pos_y) + 24, int'(pos_x) - 4, int'(pos_x) + w + 4);
        end

        repeat (6) @(posedge vga_clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
